// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron MAC datapath.
// Holds the sequencer FSM encoding and the saturating accumulator add.
package nn_pkg;

  localparam int WEIGHT_W_DEF = 12;
  localparam int PROD_W_DEF   = 19;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic               ovf;
    logic signed [31:0] sum;
  } sat_t;

  // Sum is formed one bit wider than either operand, then clamped to w bits.
  function automatic sat_t sat_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sat_t               r;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    r.ovf = 1'b0;
    r.sum = s[31:0];
    if (s > hi) begin
      r.ovf = 1'b1;
      r.sum = hi[31:0];
    end else if (s < lo) begin
      r.ovf = 1'b1;
      r.sum = lo[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// Bus between the sequencer, the layer controller,
// the weight RAM and the shared multiplier.
interface neuron_mac_sequencer_if #(
  parameter int N_INPUTS = 16,
  parameter int WEIGHT_W = 12,
  parameter int PROD_W   = 19,
  parameter int ACC_W    = 19
);

  localparam int AW = $clog2(N_INPUTS);

  logic                start;
  logic [N_INPUTS-1:0] pixel_vec;
  logic                busy;
  logic                done;
  logic                weight_rd_en;
  logic [AW-1:0]       weight_addr;
  logic [WEIGHT_W-1:0] weight_data;
  logic [WEIGHT_W-1:0] mult_weight;
  logic                mult_pixel;
  logic [PROD_W-1:0]   mult_product;
  logic [ACC_W-1:0]    acc_out;
  logic                overflow;

  modport master (
    output start,
    output pixel_vec,
    output weight_data,
    output mult_product,
    input  busy,
    input  done,
    input  weight_rd_en,
    input  weight_addr,
    input  mult_weight,
    input  mult_pixel,
    input  acc_out,
    input  overflow
  );

  modport slave (
    input  start,
    input  pixel_vec,
    input  weight_data,
    input  mult_product,
    output busy,
    output done,
    output weight_rd_en,
    output weight_addr,
    output mult_weight,
    output mult_pixel,
    output acc_out,
    output overflow
  );

endinterface

// File: rtl/token_delay.sv
// Valid-token shift register; the head stage also carries
// the pair index that produced the token.
module token_delay #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic [DEPTH-1:0] o_vld,
  output logic [WIDTH-1:0] o_head
);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_head <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_head   <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_head = r_head;

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Streams one neuron's weight/pixel pairs through the shared
// multiplier and accumulates the products with saturation.
module neuron_mac_sequencer
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 16,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int PROD_W   = PROD_W_DEF,
  parameter int ACC_W    = 19,
  parameter int MULT_LAT = 3
) (
  input  logic clk,
  input  logic GlobalReset_n,
  neuron_mac_sequencer_if.slave bus
);

  localparam int AW    = $clog2(N_INPUTS);
  localparam int DEPTH = 2 + MULT_LAT;

  state_e                    r_state;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_rd_en;
  logic [AW-1:0]             r_addr;
  logic [N_INPUTS-1:0]       r_pix;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_ovf;
  logic [WEIGHT_W-1:0]       r_mw;
  logic                      r_mp;

  logic [DEPTH-1:0]          w_vld;
  logic [AW-1:0]             w_idx;
  logic                      w_dv;
  logic                      w_exit;
  logic                      w_pend;
  sat_t                      w_sat;

  token_delay #(
    .DEPTH (DEPTH),
    .WIDTH (AW)
  ) u_tok (
    .clk     (clk),
    .rst_n   (GlobalReset_n),
    .i_valid (r_rd_en),
    .i_data  (r_addr),
    .o_vld   (w_vld),
    .o_head  (w_idx)
  );

  // Stage 0 = RAM data valid, last stage = product valid.
  assign w_dv   = w_vld[0];
  assign w_exit = w_vld[DEPTH-1];
  assign w_pend = r_rd_en | (|w_vld[DEPTH-2:0]);

  assign w_sat = sat_add(
    32'(r_acc),
    32'($signed(bus.mult_product)),
    ACC_W
  );

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_addr  <= '0;
      r_pix   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_mw    <= '0;
      r_mp    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_dv) begin
        r_mw <= bus.weight_data;
        r_mp <= r_pix[w_idx];
      end
      if (w_exit) begin
        r_acc <= ACC_W'(w_sat.sum);
        if (w_sat.ovf) r_ovf <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_pix   <= bus.pixel_vec;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
            r_addr  <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (r_addr == AW'(N_INPUTS - 1)) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_addr <= r_addr + AW'(1);
          end
        end
        S_DRAIN: begin
          // Last token is retiring this cycle when nothing is behind it.
          if (!w_pend) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.weight_rd_en = r_rd_en;
  assign bus.weight_addr  = r_addr;
  assign bus.mult_weight  = r_mw;
  assign bus.mult_pixel   = r_mp;
  assign bus.acc_out      = r_acc;
  assign bus.overflow     = r_ovf;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Randomized bench for neuron_mac_sequencer; two instances
// (19- and 14-bit accumulators) share one stimulus stream.
module tb_neuron_mac_sequencer;

  localparam int N  = 16;
  localparam int L  = 3;
  localparam int WW = 12;
  localparam int PW = 19;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tb_start;
  logic [N-1:0]  tb_pix;
  logic [WW-1:0] wmem [N];
  int            total = 0;
  int            bad   = 0;

  neuron_mac_sequencer_if #(
    .N_INPUTS(N), .WEIGHT_W(WW), .PROD_W(PW), .ACC_W(19)
  ) bus0 ();
  neuron_mac_sequencer_if #(
    .N_INPUTS(N), .WEIGHT_W(WW), .PROD_W(PW), .ACC_W(14)
  ) bus1 ();

  neuron_mac_sequencer #(
    .N_INPUTS(N), .WEIGHT_W(WW), .PROD_W(PW),
    .ACC_W(19), .MULT_LAT(L)
  ) u_dut0 (
    .clk           (clk),
    .GlobalReset_n (rst_n),
    .bus           (bus0.slave)
  );

  neuron_mac_sequencer #(
    .N_INPUTS(N), .WEIGHT_W(WW), .PROD_W(PW),
    .ACC_W(14), .MULT_LAT(L)
  ) u_dut1 (
    .clk           (clk),
    .GlobalReset_n (rst_n),
    .bus           (bus1.slave)
  );

  always #5 clk = ~clk;

  assign bus0.start     = tb_start;
  assign bus1.start     = tb_start;
  assign bus0.pixel_vec = tb_pix;
  assign bus1.pixel_vec = tb_pix;

  // Weight RAM (1-cycle read) and multiplier (L-cycle pipe) models.
  logic signed [PW-1:0] mp0 [L];
  logic signed [PW-1:0] mp1 [L];

  always_ff @(posedge clk) begin
    if (bus0.weight_rd_en) bus0.weight_data <= wmem[bus0.weight_addr];
    if (bus1.weight_rd_en) bus1.weight_data <= wmem[bus1.weight_addr];
    mp0[0] <= bus0.mult_pixel ? PW'($signed(bus0.mult_weight)) : '0;
    mp1[0] <= bus1.mult_pixel ? PW'($signed(bus1.mult_weight)) : '0;
    for (int i = 1; i < L; i++) begin
      mp0[i] <= mp0[i-1];
      mp1[i] <= mp1[i-1];
    end
  end

  assign bus0.mult_product = mp0[L-1];
  assign bus1.mult_product = mp1[L-1];

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Dot product over selected pixels, clamped after every addition.
  function automatic void model(
    input  logic [N-1:0] pix,
    input  int           acc_w,
    output longint       acc,
    output longint       ovf
  );
    longint hi;
    longint lo;
    hi  = (longint'(1) <<< (acc_w - 1)) - 1;
    lo  = -(longint'(1) <<< (acc_w - 1));
    acc = 0;
    ovf = 0;
    for (int k = 0; k < N; k++) begin
      if (pix[k]) acc += longint'($signed(wmem[k]));
      if (acc > hi) begin
        acc = hi;
        ovf = 1;
      end else if (acc < lo) begin
        acc = lo;
        ovf = 1;
      end
    end
  endfunction

  function automatic longint acc0();
    return longint'($signed(bus0.acc_out));
  endfunction

  function automatic longint acc1();
    return longint'($signed(bus1.acc_out));
  endfunction

  // Called at a negedge; start goes high in the current cycle.
  task automatic run_neuron(input logic [N-1:0] pix, input bit inject);
    longint e0, o0, e1, o1;
    int     d0, d1, n0, n1;
    model(pix, 19, e0, o0);
    model(pix, 14, e1, o1);
    d0 = -1; d1 = -1; n0 = 0; n1 = 0;
    tb_start = 1'b1;
    tb_pix   = pix;
    @(posedge clk);
    #1;
    tb_start = 1'b0;
    tb_pix   = N'($urandom);
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      check("busy", longint'(bus0.busy), longint'(c <= N + 2 + L));
      check("rd_en", longint'(bus0.weight_rd_en), longint'(c <= N));
      if (c <= N)
        check("addr", longint'(bus0.weight_addr), longint'(c - 1));
      if (c >= 3 && c <= N + 2) begin
        check("mpix", longint'(bus0.mult_pixel), longint'(pix[c-3]));
        check("mwt", longint'(bus0.mult_weight), longint'(wmem[c-3]));
      end
      if (bus0.done) begin
        n0++;
        if (d0 < 0) d0 = c;
        check("acc19", acc0(), e0);
        check("ovf19", longint'(bus0.overflow), o0);
      end
      if (bus1.done) begin
        n1++;
        if (d1 < 0) d1 = c;
        check("acc14", acc1(), e1);
        check("ovf14", longint'(bus1.overflow), o1);
      end
      if (c == 23) begin
        check("acc19_hold", acc0(), e0);
        check("acc14_hold", acc1(), e1);
      end
      tb_start = inject && (c == 5 || c == 21);
    end
    check("done_cyc19", longint'(d0), longint'(N + 3 + L));
    check("done_cyc14", longint'(d1), longint'(N + 3 + L));
    check("ndone19", longint'(n0), 1);
    check("ndone14", longint'(n1), 1);
  endtask

  task automatic run_reset_mid(input logic [N-1:0] pix);
    longint p0, q0, p1, q1;
    int     nd;
    // Products for pairs 0..3 have retired by the end of cycle 9.
    model(pix & N'(16'h000F), 19, p0, q0);
    model(pix & N'(16'h000F), 14, p1, q1);
    tb_start = 1'b1;
    tb_pix   = pix;
    @(posedge clk);
    #1;
    tb_start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    check("rst_busy_pre", longint'(bus0.busy), 1);
    check("rst_acc19_pre", acc0(), p0);
    check("rst_acc14_pre", acc1(), p1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", longint'(bus0.busy), 0);
    check("rst_rd_en", longint'(bus0.weight_rd_en), 0);
    check("rst_acc19", acc0(), 0);
    check("rst_acc14", acc1(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus0.done) nd++;
      if (bus1.done) nd++;
    end
    check("rst_no_done", longint'(nd), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    tb_start = 1'b0;
    tb_pix   = '0;
    for (int k = 0; k < N; k++) wmem[k] = '0;
    repeat (2) @(negedge clk);
    check("r_busy", longint'(bus0.busy), 0);
    check("r_done", longint'(bus0.done), 0);
    check("r_rd_en", longint'(bus0.weight_rd_en), 0);
    check("r_addr", longint'(bus0.weight_addr), 0);
    check("r_acc", acc0(), 0);
    check("r_ovf", longint'(bus0.overflow), 0);
    check("r_mwt", longint'(bus0.mult_weight), 0);
    check("r_mpix", longint'(bus0.mult_pixel), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < N; k++) wmem[k] = 12'h030;
    run_neuron(16'hFFFF, 1'b0);

    for (int k = 0; k < N; k++) wmem[k] = WW'(k);
    run_neuron(16'hAAAA, 1'b0);

    for (int k = 0; k < N; k++) wmem[k] = 12'hFFF;
    run_neuron(16'hFFFF, 1'b0);

    for (int k = 0; k < N; k++) wmem[k] = 12'h7FF;
    run_neuron(16'hFFFF, 1'b0);

    for (int k = 0; k < N; k++) wmem[k] = 12'h000;
    run_neuron(16'hFFFF, 1'b0);

    // Saturate early, then fall back into range: flag must stay set.
    for (int k = 0; k < N; k++) wmem[k] = (k < 8) ? 12'h7FF : 12'hF00;
    run_neuron(16'hFFFF, 1'b0);

    // Ignored starts mid-run, then a back-to-back start in cycle 23.
    for (int k = 0; k < N; k++) wmem[k] = WW'($urandom);
    run_neuron(N'($urandom), 1'b1);
    run_neuron(N'($urandom), 1'b0);

    for (int k = 0; k < N; k++) wmem[k] = WW'($urandom_range(1, 2047));
    run_reset_mid(16'hFFFF);
    run_neuron(N'($urandom), 1'b0);

    repeat (5) begin
      for (int k = 0; k < N; k++) wmem[k] = WW'($urandom);
      run_neuron(N'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_mac_sequencer.md
# neuron_mac_sequencer

Sequences one neuron's dot product through the shared `FixedPointMultiplier`. On `start` it latches a binary pixel vector and fetches `N_INPUTS` 12-bit weights from weight memory. It feeds each weight/pixel pair to the multiplier, collects the products after the multiplier's fixed latency, and accumulates them with signed saturation. It sits between the layer controller (start/done) and the multiplier/weight RAM pair.

## Interface
- `N_INPUTS`, 16: pixel/weight pairs per neuron, ≥2.
- `WEIGHT_W`, 12: weight width (signed).
- `PROD_W`, 19: multiplier product width (signed).
- `ACC_W`, 19: accumulator width (signed), ≥`PROD_W`-6.
- `MULT_LAT`, 3: cycles from operands presented to `mult_product` valid, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `GlobalReset_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a neuron; sampled only in IDLE.
- `pixel_vec` in `N_INPUTS`: binary pixels; latched on accepted start.
- `busy` out 1: high from accepted start through done cycle exclusive.
- `done` out 1: one-cycle pulse; `acc_out`/`overflow` valid.
- `weight_rd_en` out 1: weight RAM read strobe.
- `weight_addr` out `$clog2(N_INPUTS)`: weight index.
- `weight_data` in `WEIGHT_W`: RAM data, valid the cycle after `weight_rd_en`.
- `mult_weight` out `WEIGHT_W`: registered multiplier weight operand (`WeightPort`).
- `mult_pixel` out 1: registered multiplier pixel operand (`PixelPort`).
- `mult_product` in `PROD_W`: multiplier output (`Output_syn`).
- `acc_out` out `ACC_W`: accumulated sum; held after done.
- `overflow` out 1: sticky saturation flag for the current neuron.

## Operation
- FSM: IDLE → FETCH → DRAIN → DONE → IDLE.
- IDLE: `start`=1 latches `pixel_vec`, clears `acc_out` and `overflow`, and goes to FETCH.
- FETCH: lasts N_INPUTS cycles. Cycle k asserts `weight_rd_en` with `weight_addr`=k (k=0..N-1). After the last issue the FSM goes to DRAIN.
- Operand stage: the cycle after read k, register `mult_weight`←`weight_data` and `mult_pixel`←`pixel_vec[k]`. A valid token shift register of depth 2+`MULT_LAT` tracks each pair in flight.
- Accumulate: when a token exits, `acc` ← sat(`acc` + sext(`mult_product`)), computed at `ACC_W`+1 bits. Clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set `overflow`. Once set, `overflow` stays set until the next accepted start, even if later sums return in range.
- DRAIN: wait until the token pipe is empty, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while not IDLE is ignored; there is no queueing.
- `pixel_vec` changes after latch have no effect.
- Outside FETCH, `weight_rd_en`=0. Between pairs, `mult_weight` and `mult_pixel` hold their last value.

## Timing
- Cycle 0 is the edge at which `start` is sampled.
- Cycle 1+k: read k issued.
- Cycle 2+k: `weight_data` valid.
- Cycle 3+k: operands presented.
- Cycle 3+k+`MULT_LAT`: product accumulated at the end of that cycle.
- `done` is high in cycle `N_INPUTS`+3+`MULT_LAT`; with defaults that is cycle 22.
- `busy` is high in cycles 1 through `N_INPUTS`+2+`MULT_LAT`.
- Next start is accepted in the cycle after `done` at the earliest.
- Reset values: state IDLE, all outputs 0 (`acc_out`=0, `overflow`=0, `mult_weight`=0, `mult_pixel`=0, `weight_addr`=0).
- Reset mid-operation: all state and in-flight tokens are discarded immediately. No `done` is produced.

## Structure
- Shared package `nn_pkg`:
  - FSM state enum.
  - `WEIGHT_W`/`PROD_W` defaults.
  - Saturating-add function.
- Sub-module `token_delay` (parameterised depth shift register with reset) tracks operand validity and the pixel index.
- The multiplier and weight RAM are external.

## Test plan
- All pixels 1, every weight 0x030 (48), defaults → `done` in cycle 22, `acc_out`=768, `overflow`=0, `busy` high cycles 1–21.
- `pixel_vec`=0xAAAA, weight[k]=k → `acc_out`=64 (odd k 1..15), and `mult_pixel` alternates 0/1 starting at 0 in cycle 3.
- Signed weights: all pixels 1, weight[k]=0xFFF (-1) → `acc_out`=-16 (0x7FFF0 at 19 bits).
- Saturation with `ACC_W`=14: all pixels 1, weights 0x7FF → `acc_out`=8191, `overflow`=1. The next start with weights 0 → `acc_out`=0, `overflow`=0.
- `start` pulsed in cycles 5 and 21 of a run → ignored; exactly one `done` in cycle 22. A start in cycle 23 is accepted, giving `done` in cycle 45.
- `GlobalReset_n` low in cycle 10 → `busy`, `weight_rd_en` and `acc_out` go to 0 asynchronously, and no `done` follows. A fresh start after release completes normally with the correct sum.
